// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and widths for the counter widener
package counter_pkg;
  localparam int FullWidth = 64;
  typedef enum logic [1:0] {UNSYNC, TRACK, FAULT} state_t;
endpackage

// File: rtl/counter_step_check.sv
// counter_step_check: modular step between samples, step legality and low-field wrap detect
module counter_step_check #(
  parameter int              CounterWidth = 32,
  parameter longint unsigned MaxStep      = 1
) (
  input  logic [CounterWidth-1:0] prev_low,
  input  logic [CounterWidth-1:0] cur,
  output logic [CounterWidth-1:0] delta,
  output logic                    legal,
  output logic                    wrapped
);
  assign delta   = cur - prev_low;
  assign legal   = delta != '0 && delta <= CounterWidth'(MaxStep);
  // a legal forward step that lands below the previous low field crossed 2^CounterWidth
  assign wrapped = legal && cur < prev_low;
endmodule

// File: rtl/counter_widen.sv
// counter_widen: rebuilds a 64-bit counter from its truncated low bits,
// tracking wraps of the low field and flagging illegal steps.
module counter_widen
  import counter_pkg::*;
#(
  parameter int              CounterWidth = 32,
  parameter longint unsigned MaxStep      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CounterWidth-1:0] in_count,
  input  logic                    resync,
  output logic                    out_valid,
  output logic [FullWidth-1:0]    out_count,
  output logic                    wrap,
  output logic                    err,
  output logic                    overflow
);
  localparam int UpperWidth = FullWidth - CounterWidth;
  state_t                  state, state_d;
  logic [FullWidth-1:0]    count_d;
  logic                    valid_d, wrap_d, err_d, ovf_d;
  logic [CounterWidth-1:0] delta;
  logic                    legal, wrapped, carry;
  logic [UpperWidth-1:0]   upper, upper_inc;

  assign upper = out_count[FullWidth-1:CounterWidth];
  // carry out of the upper field feeds only the overflow flag
  assign {carry, upper_inc} = {1'b0, upper} + (UpperWidth + 1)'(1);

  counter_step_check #(
    .CounterWidth(CounterWidth),
    .MaxStep     (MaxStep)
  ) u_step (
    .prev_low(out_count[CounterWidth-1:0]),
    .cur     (in_count),
    .delta   (delta),
    .legal   (legal),
    .wrapped (wrapped)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= UNSYNC;
    else     state <= state_d;

  always_comb
    state_d = resync                                     ? UNSYNC :
              !in_valid                                  ? state  :
              state == UNSYNC                            ? TRACK  :
              state == TRACK && delta != '0 && !legal    ? FAULT  : state;

  always_comb begin
    count_d = out_count;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err;
    ovf_d   = overflow;
    if (resync) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end else if (in_valid && state == UNSYNC) begin
      count_d = FullWidth'(in_count);
      valid_d = 1'b1;
    end else if (in_valid && state == TRACK) begin
      if (delta == '0) begin
        valid_d = 1'b1;
      end else if (legal) begin
        count_d = {wrapped ? upper_inc : upper, in_count};
        valid_d = 1'b1;
        wrap_d  = wrapped;
        ovf_d   = overflow | (wrapped & carry);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_count <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_count <= count_d;
      out_valid <= valid_d;
      wrap      <= wrap_d;
      err       <= err_d;
      overflow  <= ovf_d;
    end
endmodule

// File: tb/tb_counter_widen.sv
// tb_counter_widen: random and directed checks of three counter_widen configurations against a value-level model
module tb_counter_widen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, a_rs = 1'b0, w_valid = 1'b0, w_rs = 1'b0;
  logic [7:0]  a_cnt = '0;
  logic [62:0] w_cnt = '0;
  logic        ov[3], ow[3], oe[3], oo[3];
  logic [63:0] oc[3];
  logic [63:0] m_cnt[3];
  bit          m_sync[3], m_v[3], m_w[3], m_e[3], m_o[3];
  int          n_chk = 0, n_bad = 0;
  logic [7:0]  last_a = '0;
  logic [62:0] last_w = '0;

  always #5 clk = ~clk;

  counter_widen #(.CounterWidth(8), .MaxStep(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_count(a_cnt), .resync(a_rs),
    .out_valid(ov[0]), .out_count(oc[0]), .wrap(ow[0]), .err(oe[0]), .overflow(oo[0]));
  counter_widen #(.CounterWidth(8), .MaxStep(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_count(a_cnt), .resync(a_rs),
    .out_valid(ov[1]), .out_count(oc[1]), .wrap(ow[1]), .err(oe[1]), .overflow(oo[1]));
  counter_widen #(.CounterWidth(63), .MaxStep(64'h3FFF_FFFF_FFFF_FFFF)) dw (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_count(w_cnt), .resync(w_rs),
    .out_valid(ov[2]), .out_count(oc[2]), .wrap(ow[2]), .err(oe[2]), .overflow(oo[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // the counter simply advances by the step; wrap/overflow are crossings of 2^cw and 2^64
  task automatic model(input int i, input bit v, input logic [63:0] x, input bit rs);
    logic [63:0] mask, lo, d, ms;
    logic [64:0] sum;
    mask = i == 2 ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFF;
    ms   = i == 0 ? 64'd1 : i == 1 ? 64'd4 : 64'h3FFF_FFFF_FFFF_FFFF;
    lo   = m_cnt[i] & mask;
    m_v[i] = 0;
    m_w[i] = 0;
    if (rs) begin
      m_sync[i] = 0;
      m_e[i]    = 0;
      m_o[i]    = 0;
    end else if (v && !m_e[i]) begin
      if (!m_sync[i]) begin
        m_cnt[i]  = x;
        m_v[i]    = 1;
        m_sync[i] = 1;
      end else begin
        d = (x - lo) & mask;
        if (d == 0) m_v[i] = 1;
        else if (d <= ms) begin
          sum      = {1'b0, m_cnt[i]} + {1'b0, d};
          m_cnt[i] = sum[63:0];
          m_o[i]   = m_o[i] | sum[64];
          m_w[i]   = lo + d > mask;
          m_v[i]   = 1;
        end else m_e[i] = 1;
      end
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = '0; m_sync[i] = 0; m_v[i] = 0; m_w[i] = 0; m_e[i] = 0; m_o[i] = 0;
    end
  endtask

  task automatic check_all;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid%0d", i), 64'(ov[i]), 64'(m_v[i]));
      check($sformatf("wrap%0d", i), 64'(ow[i]), 64'(m_w[i]));
      check($sformatf("err%0d", i), 64'(oe[i]), 64'(m_e[i]));
      check($sformatf("ovf%0d", i), 64'(oo[i]), 64'(m_o[i]));
      check($sformatf("count%0d", i), oc[i], m_cnt[i]);
    end
  endtask

  task automatic step(input bit av, input logic [7:0] ac, input bit ars,
                      input bit wv, input logic [62:0] wc, input bit wrs);
    @(negedge clk);
    a_valid = av; a_cnt = ac; a_rs = ars;
    w_valid = wv; w_cnt = wc; w_rs = wrs;
    @(posedge clk);
    model(0, av, {56'b0, ac}, ars);
    model(1, av, {56'b0, ac}, ars);
    model(2, wv, {1'b0, wc}, wrs);
    #1 check_all;
  endtask

  task automatic sa(input logic [7:0] ac);
    step(1, ac, 0, 0, '0, 0);
  endtask

  task automatic sw(input logic [62:0] wc);
    step(0, '0, 0, 1, wc, 0);
  endtask

  // async reset lands mid-cycle with a sample pending, then releases with idle inputs
  task automatic hit_rst(input bit av, input logic [7:0] ac);
    @(negedge clk);
    a_valid = av; a_cnt = ac; a_rs = 0;
    w_valid = av; w_cnt = {55'b0, ac}; w_rs = 0;
    #2 rst = 1;
    #1 model_reset;
    check_all;
    @(negedge clk);
    a_valid = 0; w_valid = 0; rst = 0;
    @(posedge clk);
    model(0, 0, '0, 0);
    model(1, 0, '0, 0);
    model(2, 0, '0, 0);
    #1 check_all;
  endtask

  initial begin
    model_reset;
    repeat (2) @(posedge clk);
    #1 check_all;
    check("rst_count", oc[0], 64'h0);
    @(negedge clk) rst = 0;

    sa(8'h05); check("r33_a", oc[0], 64'h05);
    sa(8'h06); check("r33_b", oc[0], 64'h06);
    sa(8'h07); check("r33_c", oc[0], 64'h07); check("r33_wrap", 64'(ow[0]), 64'h0);

    step(0, '0, 1, 0, '0, 1);
    sa(8'hFE); sa(8'hFF);
    check("r34_ff", oc[0], 64'hFF);
    sa(8'h00); check("r34_100", oc[0], 64'h100); check("r34_wrap", 64'(ow[0]), 64'h1);
    sa(8'h01); check("r34_101", oc[0], 64'h101); check("r34_nowrap", 64'(ow[0]), 64'h0);

    step(0, '0, 1, 0, '0, 0);
    sa(8'h10); sa(8'h13);
    check("r35_err", 64'(oe[0]), 64'h1);
    check("r35_hold", oc[0], 64'h10);
    check("r35_novalid", 64'(ov[0]), 64'h0);
    check("r35_ms4", oc[1], 64'h13);
    step(1, 8'h99, 1, 0, '0, 0);
    sa(8'h40); check("r35_load", oc[0], 64'h40); check("r35_clr", 64'(oe[0]), 64'h0);

    step(0, '0, 1, 0, '0, 0);
    sa(8'hFD); sa(8'h01);
    check("r36_cnt", oc[1], 64'h101); check("r36_wrap", 64'(ow[1]), 64'h1);
    sa(8'h01);
    check("r36_rep", oc[1], 64'h101); check("r36_rwrap", 64'(ow[1]), 64'h0);
    check("r36_rvalid", 64'(ov[1]), 64'h1);

    step(0, '0, 0, 0, '0, 1);
    sw(63'h7FFF_FFFF_FFFF_FFF0);
    sw(63'h10); check("r37_up", oc[2], 64'h8000_0000_0000_0010);
    sw(63'h4000_0000_0000_000F);
    sw(63'h7FFF_FFFF_FFFF_FFFE);
    sw(63'h7FFF_FFFF_FFFF_FFFF); check("r37_ones", oc[2], 64'hFFFF_FFFF_FFFF_FFFF);
    sw(63'h0);
    check("r37_zero", oc[2], 64'h0);
    check("r37_ovf", 64'(oo[2]), 64'h1);
    check("r37_wrap", 64'(ow[2]), 64'h1);

    step(0, '0, 1, 0, '0, 1);
    sa(8'h22);
    hit_rst(1, 8'h23);
    check("r38_zero", oc[0], 64'h0);
    sa(8'h80); check("r38_load", oc[0], 64'h80); check("r38_valid", 64'(ov[0]), 64'h1);

    last_a = 8'h80;
    last_w = '0;
    for (int n = 0; n < 1500; n++) begin
      int r, sh;
      bit av, wv, ars, wrs;
      logic [7:0]  ac;
      logic [62:0] wc;
      if ($urandom_range(0, 299) == 0) hit_rst($urandom_range(0, 1) == 1, 8'($urandom));
      r   = $urandom_range(0, 99);
      ac  = last_a + (r < 70 ? 8'($urandom_range(0, 1)) : r < 95 ? 8'($urandom_range(2, 4))
                                                                  : 8'($urandom_range(5, 255)));
      av  = $urandom_range(0, 3) != 0;
      ars = $urandom_range(0, 29) == 0;
      sh  = $urandom_range(1, 40);
      wc  = last_w + 63'({$urandom, $urandom} >> sh);
      wv  = $urandom_range(0, 3) != 0;
      wrs = $urandom_range(0, 29) == 0;
      if (av) last_a = ac;
      if (wv) last_w = wc;
      step(av, ac, ars, wv, wc, wrs);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_widen.md
COUNTER_WIDEN -- requirements
Module: counter_widen

Interface
REQ-001 The block SHALL have parameter CounterWidth, default 32, giving the width of the truncated counter sample; legal range 2..63.
REQ-002 The block SHALL have parameter MaxStep, default 1, giving the largest legal forward step between consecutive samples, modulo 2^CounterWidth; legal range 1..2^(CounterWidth-1)-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_count is valid this cycle.
REQ-006 The block SHALL have port in_count, input, CounterWidth bits: the truncated low bits of a 64-bit free-running counter.
REQ-007 The block SHALL have port resync, input, 1 bit: a synchronous request to drop tracking and return to UNSYNC.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_count is updated this cycle.
REQ-009 The block SHALL have port out_count, output, 64 bits: the reconstructed full counter value.
REQ-010 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse meaning the low field wrapped on this output.
REQ-011 The block SHALL have port err, output, 1 bit: a sticky flag meaning an illegal step was seen; the block is in FAULT.
REQ-012 The block SHALL have port overflow, output, 1 bit: a sticky flag meaning the 64-bit reconstruction wrapped past all-ones.

Function
REQ-013 The block SHALL implement the states UNSYNC, TRACK and FAULT.
REQ-014 In UNSYNC, on in_valid, the block SHALL load out_count = zero-extended in_count, assert out_valid the next cycle, and go to TRACK.
REQ-015 In TRACK, on in_valid, the block SHALL compute delta = (in_count - low field of out_count) mod 2^CounterWidth.
REQ-016 If delta = 0, the block SHALL re-emit out_count unchanged, assert out_valid and leave wrap low.
REQ-017 If 1 <= delta <= MaxStep and in_count >= the previous low field, the block SHALL set out_count = {upper bits, in_count}.
REQ-018 If 1 <= delta <= MaxStep and in_count < the previous low field, the block SHALL increment the upper (64-CounterWidth) bits, set the low field to in_count, and pulse wrap with out_valid.
REQ-019 If the upper field is all-ones at a wrap, the block SHALL wrap out_count to {0, in_count} and set overflow.
REQ-020 If delta > MaxStep, the block SHALL hold out_count, leave out_valid low, set err and go to FAULT.
REQ-021 In FAULT, the block SHALL ignore in_valid, keep out_valid low and hold out_count.
REQ-022 resync SHALL move any state to UNSYNC on the next edge and clear err and overflow.
REQ-023 If resync and in_valid are both high, resync SHALL win and the sample SHALL be discarded.
REQ-024 Latency SHALL be exactly 1 cycle from an accepted in_valid to out_valid; out_valid and wrap SHALL be registered single-cycle pulses.
REQ-025 Back-to-back in_valid SHALL be accepted every cycle with no stall.
REQ-026 All arithmetic SHALL be unsigned and widths explicit; delta SHALL be CounterWidth bits, the upper increment SHALL be 64-CounterWidth bits, and any carry-out SHALL go only to overflow.

Reset
REQ-027 On rst high, the block SHALL immediately set: state UNSYNC, out_count 0, out_valid 0, wrap 0, err 0, overflow 0.
REQ-028 A reset asserted mid-stream SHALL discard any in-flight sample, and no out_valid SHALL appear in the cycle after rst deasserts.
REQ-029 rst SHALL be asserted asynchronously and released synchronously to clk by the integrator; the block itself SHALL not synchronise it.

Structure
REQ-030 A shared package counter_pkg SHALL hold the state enum (UNSYNC, TRACK, FAULT) and the constant FullWidth = 64.
REQ-031 One sub-module counter_step_check SHALL be used: combinational delta, step-legal and wrap-detect, parameterised by CounterWidth and MaxStep.
REQ-032 The top SHALL hold the FSM, the registers and the flags.

Verification (CounterWidth=8, MaxStep=1 unless noted)
REQ-033 Reset, then samples 0x05, 0x06, 0x07 -> out_count 0x05, 0x06, 0x07, each one cycle after its sample, with wrap=0.
REQ-034 Tracking at 0xFE, then samples 0xFF, 0x00, 0x01 -> out_count 0xFF, 0x100, 0x101, with the wrap pulse only on 0x100.
REQ-035 At 0x10, sample 0x13 -> err=1, out_count held at 0x10, out_valid low; then resync and sample 0x40 -> out_count 0x40, err=0.
REQ-036 MaxStep=4, at 0xFD, sample 0x01 -> out_count 0x101 with wrap=1; a repeated sample 0x01 -> out_count 0x101 with wrap=0.
REQ-037 Upper field forced to all-ones with low 0xFF, sample 0x00 -> out_count 0, overflow=1, wrap=1.
REQ-038 rst pulsed between two valid samples -> outputs 0 immediately, and the next sample is loaded as in UNSYNC.
